operand_sequencer: RTL and testbench

Two-requester front end for the four-operand capture/compute datapath. Accepts a packed four-operand word from either requester over a valid/ready handshake and arbitrates round-robin between them. Serialises the word into four capture cycles on the datapath's `d_in`/`op`/`capture` inputs, waits for the datapath's one-cycle `valid` pulse, and returns the 5-bit result with the requester ID over a valid/ready response channel.

---
 rtl/operand_sequencer_pkg.sv | 22 ++
 rtl/operand_sequencer_rr_arb2.sv | 28 ++
 rtl/operand_sequencer.sv | 173 +++++++++++++++++
 tb/tb_operand_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_sequencer_pkg.sv
// opseq_pkg: shared definitions for operand_sequencer.
//   opseq_state_t : sequencer FSM states (IDLE, LOAD, WAIT, RESP)
//   OP_A..OP_D    : datapath operand-select codes driven on dp_op
//   DW, RW        : default operand and result widths
package opseq_pkg;

  localparam int unsigned DW = 4;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } opseq_state_t;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_D = 2'd3;

endpackage

// File: rtl/operand_sequencer_rr_arb2.sv
// rr_arb2: combinational two-input round-robin arbiter.
//   valid0, valid1 : request present from requester 0 / 1
//   last_id        : requester granted at the previous handshake (registered by parent)
//   grant          : one-hot grant, bit N = requester N; zero when nobody is valid
//   grant_id       : index of the granted requester
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_id,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_id;
    end else if (valid1) begin
      grant_id = 1'b1;
    end

    grant = '0;
    if (valid0 || valid1) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: two-requester front end for the four-operand
// capture/compute datapath. Accepts a packed {A,B,C,D} word over valid/ready,
// arbitrates round-robin, serialises the operands into four capture cycles,
// waits for the datapath valid pulse and returns the result with the
// requester ID over a valid/ready response channel.
//
// Optional feature macro: OPSEQ_TIMEOUT_EN
//   defined   : WAIT aborts after WAIT_MAX cycles, pulsing dp_rst_n low for one
//               cycle and responding with rsp_err=1, rsp_result=0.
//   undefined : WAIT holds indefinitely, rsp_err=0, dp_rst_n=rst_n.
//
// Ports:
//   clock, rst_n              : clock, synchronous active-low reset
//   req0_*/req1_*             : request channels (valid, 4*DW data, ready)
//   dp_d_in, dp_op, dp_capture: operand, operand select and capture strobe
//   dp_rst_n                  : datapath reset (rst_n, optionally gated by abort)
//   dp_result, dp_valid       : datapath result and all-captured pulse
//   rsp_valid, rsp_ready      : response handshake
//   rsp_result, rsp_id, rsp_err: latched result, requester ID, timeout flag
module operand_sequencer #(
  parameter int unsigned DW       = opseq_pkg::DW,
  parameter int unsigned RW       = opseq_pkg::RW,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [4*DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [4*DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] dp_d_in,
  output logic [1:0]    dp_op,
  output logic          dp_capture,
  output logic          dp_rst_n,
  input  logic [RW-1:0] dp_result,
  input  logic          dp_valid,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_result,
  output logic          rsp_id,
  output logic          rsp_err
);

  import opseq_pkg::*;

  opseq_state_t    state;
  logic [4*DW-1:0] opword;
  logic            cur_id;
  logic            last_id;
  logic [1:0]      grant;
  logic            grant_id;
  logic            accept;
  logic [4*DW-1:0] req_word;

  rr_arb2 u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last_id  (last_id),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req0_ready = rst_n && (state == IDLE) && grant[0];
  assign req1_ready = rst_n && (state == IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign req_word   = grant_id ? req1_data : req0_data;

`ifdef OPSEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;
  logic          abort;
  logic          err_q;

  assign dp_rst_n = rst_n & ~abort;
  assign rsp_err  = err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign dp_rst_n = rst_n;
  assign rsp_err  = 1'b0;
`endif

  // opword is kept as a shift register: the next operand to present is
  // always in the top DW bits, so A..D leave in order without an index mux.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= IDLE;
      opword     <= '0;
      cur_id     <= 1'b0;
      last_id    <= 1'b1;
      dp_d_in    <= '0;
      dp_op      <= OP_A;
      dp_capture <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
`ifdef OPSEQ_TIMEOUT_EN
      wait_cnt   <= '0;
      abort      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef OPSEQ_TIMEOUT_EN
      abort <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            opword     <= req_word << DW;
            cur_id     <= grant_id;
            last_id    <= grant_id;
            dp_d_in    <= req_word[4*DW-1 -: DW];
            dp_op      <= OP_A;
            dp_capture <= 1'b1;
            state      <= LOAD;
          end
        end

        LOAD: begin
          dp_d_in <= opword[4*DW-1 -: DW];
          opword  <= opword << DW;
          unique case (dp_op)
            OP_A:    dp_op <= OP_B;
            OP_B:    dp_op <= OP_C;
            OP_C:    dp_op <= OP_D;
            default: begin
              dp_d_in    <= dp_d_in;
              dp_capture <= 1'b0;
              state      <= WAIT;
`ifdef OPSEQ_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end
          endcase
        end

        WAIT: begin
          if (dp_valid) begin
            rsp_result <= dp_result;
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= RESP;
`ifdef OPSEQ_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            // Last allowed WAIT cycle passed without dp_valid.
            abort      <= 1'b1;
            rsp_result <= '0;
            rsp_id     <= cur_id;
            err_q      <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt   <= wait_cnt + CW'(1);
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [3:0]  dp_d_in;
  logic [1:0]  dp_op;
  logic        dp_capture;
  logic        dp_rst_n;
  logic [4:0]  dp_result;
  logic        dp_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_result;
  logic        rsp_id;
  logic        rsp_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        m_last_id;

  operand_sequencer dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .dp_d_in    (dp_d_in),
    .dp_op      (dp_op),
    .dp_capture (dp_capture),
    .dp_rst_n   (dp_rst_n),
    .dp_result  (dp_result),
    .dp_valid   (dp_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference datapath function: sum of the four operands, modulo 32.
  function automatic logic [4:0] model_result(input logic [15:0] w);
    int unsigned s;
    s = w[15:12] + w[11:8] + w[7:4] + w[3:0];
    return 5'(s % 32);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    dp_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    m_last_id = 1'b1;
  endtask

  // One full transaction starting in the current (IDLE) cycle.
  task automatic transact(input logic [1:0] vmask, input logic [15:0] d0, input logic [15:0] d1,
                          input logic keep, input int unsigned dv_delay, input int unsigned bp,
                          input logic stray, output logic gid);
    logic [15:0] w;
    logic [4:0]  exp_res;
    req0_valid = vmask[0]; req0_data = d0;
    req1_valid = vmask[1]; req1_data = d1;
    #1;
    gid = (vmask == 2'b11) ? ~m_last_id : vmask[1];
    checks++;
    if (req0_ready !== (gid == 1'b0) || req1_ready !== (gid == 1'b1)) begin
      errors++;
      $display("FAIL grant: ready0=%b ready1=%b expected grant to req%0d", req0_ready, req1_ready, gid);
    end
    w = gid ? d1 : d0;
    exp_res = model_result(w);
    @(posedge clock);
    m_last_id = gid;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      dp_valid = stray && (k == 1);
      dp_result = 5'($urandom);
      #1;
      checks++;
      if (dp_capture !== 1'b1 || dp_op !== 2'(k) || dp_d_in !== w[15-4*k -: 4] ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL load%0d: capture=%b op=%0d d_in=%h rdy=%b%b rsp_valid=%b expected capture=1 op=%0d d_in=%h rdy=00 rsp_valid=0",
                 k, dp_capture, dp_op, dp_d_in, req1_ready, req0_ready, rsp_valid, k, w[15-4*k -: 4]);
      end
    end
    for (int d = 0; d <= int'(dv_delay); d++) begin
      @(negedge clock);
      dp_valid = (d == int'(dv_delay));
      dp_result = (d == int'(dv_delay)) ? exp_res : 5'($urandom);
      #1;
      checks++;
      if (dp_capture !== 1'b0 || rsp_valid !== 1'b0 || dp_rst_n !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait%0d: capture=%b rsp_valid=%b dp_rst_n=%b rdy=%b%b expected 0 0 1 00",
                 d, dp_capture, rsp_valid, dp_rst_n, req1_ready, req0_ready);
      end
    end
    @(negedge clock);
    dp_valid = 1'b0;
    dp_result = 5'($urandom);
    rsp_ready = (bp == 0);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_id !== gid || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL response: valid=%b result=%h id=%b err=%b expected 1 %h %b 0",
               rsp_valid, rsp_result, rsp_id, rsp_err, exp_res, gid);
    end
    for (int b = 0; b < int'(bp); b++) begin
      @(negedge clock);
      dp_result = 5'($urandom);
      if (b == int'(bp) - 1) rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_id !== gid ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: valid=%b result=%h id=%b rdy=%b%b expected 1 %h %b 00",
                 b, rsp_valid, rsp_result, rsp_id, req1_ready, req0_ready, exp_res, gid);
      end
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_done: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || dp_d_in !== 4'h0 || dp_op !== 2'd0 ||
        dp_capture !== 1'b0 || dp_rst_n !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 5'h0 ||
        rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b d_in=%h op=%0d cap=%b dp_rst_n=%b rv=%b res=%h id=%b err=%b expected all 0",
               req1_ready, req0_ready, dp_d_in, dp_op, dp_capture, dp_rst_n, rsp_valid, rsp_result, rsp_id, rsp_err);
    end
    rst_n = 1'b1;
    m_last_id = 1'b1;
  endtask

  task automatic test_single_op();
    logic g;
    transact(2'b01, 16'h1234, 16'($urandom), 1'b0, 0, 0, 1'b0, g);
    checks++;
    if (g !== 1'b0 || rsp_result !== 5'h0A) begin
      errors++;
      $display("FAIL single_op: result=%h expected 0a", rsp_result);
    end
  endtask

  task automatic test_tie();
    logic g;
    logic [2:0] seq;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      transact(2'b11, 16'($urandom), 16'($urandom), 1'b1, 0, 0, 1'b0, g);
      seq[i] = g;
    end
    checks++;
    if (seq !== 3'b010) begin
      errors++;
      $display("FAIL tie_order: grants (i2..i0)=%b expected 010", seq);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic g;
    transact(2'b11, 16'($urandom), 16'($urandom), 1'b1, 0, 5, 1'b0, g);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic g;
    req0_valid = 1'b1; req0_data = 16'($urandom);
    @(posedge clock);
    m_last_id = 1'b0;
    @(negedge clock); req0_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (dp_op !== 2'd2 || dp_capture !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_idx: op=%0d cap=%b expected 2 1", dp_op, dp_capture);
    end
    rst_n = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (dp_capture !== 1'b0 || dp_op !== 2'd0 || dp_d_in !== 4'h0 || rsp_valid !== 1'b0 ||
        dp_rst_n !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 5'h0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL mid_load_reset: cap=%b op=%0d d_in=%h rv=%b dp_rst_n=%b expected 0 0 0 0 0",
               dp_capture, dp_op, dp_d_in, rsp_valid, dp_rst_n);
    end
    rst_n = 1'b1;
    m_last_id = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      dp_valid = (i == 2);
      dp_result = 5'($urandom);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || dp_capture !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle%0d: rv=%b cap=%b expected 0 0", i, rsp_valid, dp_capture);
      end
    end
    dp_valid = 1'b0;
    // last_id must be back at 1, so req0 wins this tie
    transact(2'b11, 16'($urandom), 16'($urandom), 1'b0, 1, 0, 1'b0, g);
  endtask

  task automatic test_stray();
    logic g;
    dp_valid = 1'b1; dp_result = 5'($urandom);
    @(negedge clock);
    dp_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: rsp_valid=%b expected 0", rsp_valid);
    end
    transact(2'b10, 16'($urandom), 16'($urandom), 1'b0, 0, 1, 1'b1, g);
  endtask

  task automatic test_wait_limit();
    logic g;
`ifdef OPSEQ_TIMEOUT_EN
    // dp_valid on the final allowed WAIT cycle still yields a normal result
    transact(2'b01, 16'($urandom), 16'($urandom), 1'b0, 14, 0, 1'b0, g);
    req1_valid = 1'b1; req1_data = 16'($urandom);
    @(posedge clock);
    m_last_id = 1'b1;
    @(negedge clock); req1_valid = 1'b0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 15; d++) begin
      @(negedge clock);
      #1;
      checks++;
      if (dp_rst_n !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d: dp_rst_n=%b rv=%b expected 1 0", d, dp_rst_n, rsp_valid);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (dp_rst_n !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 5'h0 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: dp_rst_n=%b rv=%b err=%b res=%h id=%b expected 0 1 1 00 1",
               dp_rst_n, rsp_valid, rsp_err, rsp_result, rsp_id);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (dp_rst_n !== 1'b1 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: dp_rst_n=%b rv=%b err=%b expected 1 1 1", dp_rst_n, rsp_valid, rsp_err);
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: rv=%b expected 0", rsp_valid);
    end
`else
    // without the timeout, a long wait still completes normally
    transact(2'b01, 16'($urandom), 16'($urandom), 1'b0, 20, 0, 1'b0, g);
`endif
  endtask

  task automatic test_random();
    logic g;
    logic [1:0] vm;
    for (int i = 0; i < 20; i++) begin
      vm = 2'($urandom_range(1, 3));
      transact(vm, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), g);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    dp_result = '0; dp_valid = 1'b0;
    rsp_ready = 1'b0;
    m_last_id = 1'b1;
    test_reset();
    test_single_op();
    test_tie();
    test_backpressure();
    test_reset_mid_load();
    test_stray();
    test_wait_limit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
